// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: jump encodings, FSM states,
// the fetched-instruction packet and reset/bubble defaults.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    JUMP_SEQ  = 2'd0,
    JUMP_BR   = 2'd1,
    JUMP_JALR = 2'd2,
    JUMP_RSVD = 2'd3
  } jump_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_pkt_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;  // wraps modulo 2^32
  endfunction

endpackage

// File: rtl/fetch_unit_ifid.sv
// IF/ID pipeline register: flush loads a bubble, stop holds, otherwise it
// takes the offered packet or a bubble when nothing is offered.
module ifid_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stop,
  input  logic        load,
  input  fetch_pkt_t  pkt,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
      id_pc    <= 32'h0000_0000;
      id_pc4   <= 32'h0000_0004;
    end else if (flush) begin
      // Bubble keeps the old pc fields so downstream sees stable values.
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (!stop) begin
      if (load) begin
        id_inst  <= pkt.inst;
        id_pc    <= pkt.pc;
        id_pc4   <= pc_plus4(pkt.pc);
        id_valid <= 1'b1;
      end else begin
        id_inst  <= NOP_INST;
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem request/ack handshake,
// applies stall/flush/redirect and skid-buffers an instruction during a stall.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_stop,
  input  logic        if_id_stop,
  input  logic        if_id_flush,
  input  logic [1:0]  jump,
  input  logic [31:0] br_target,
  input  logic [31:0] jalr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;  // address of the request being dropped
  fetch_pkt_t  buf_q, buf_d;

  logic        redirect;
  logic        stall;
  logic [31:0] target;
  logic        req_active;
  logic        ifid_load;
  fetch_pkt_t  ifid_pkt;

  // Reserved jump encoding falls through as sequential.
  always_comb begin
    redirect = (jump == JUMP_BR) || (jump == JUMP_JALR);
    target   = (jump == JUMP_BR) ? br_target : (jalr_target & 32'hFFFF_FFFE);
    stall    = pc_stop || if_id_stop;
  end

  // NOTE: every variable written below gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    buf_d       = buf_q;
    req_active  = 1'b0;
    imem_addr   = pc_q;
    ifid_load   = 1'b0;
    ifid_pkt    = '{inst: imem_rdata, pc: pc_q};

    unique case (state_q)
      S_FETCH: begin
        req_active = 1'b1;
        if (redirect) begin
          pc_d = target;
          if (!imem_ack) begin
            // Request already on the bus must complete at its original address.
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (!if_id_flush && imem_ack) begin
          pc_d = pc_plus4(pc_q);
          if (stall) begin
            buf_d   = '{inst: imem_rdata, pc: pc_q};
            state_d = S_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (if_id_flush) begin
          // Buffered instruction is squashed; refetch it after the flush.
          pc_d    = buf_q.pc;
          state_d = S_FETCH;
        end else if (!stall) begin
          ifid_load = 1'b1;
          ifid_pkt  = buf_q;
          state_d   = S_FETCH;
        end
      end

      S_DROP: begin
        req_active = 1'b1;
        imem_addr  = drop_addr_q;
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ack) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // NOTE: request is gated combinationally by rst so it drops the moment
  // reset asserts, not on the next edge.
  assign imem_req = req_active && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_q       <= buf_d;
    end
  end

  ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .flush    (if_id_flush),
    .stop     (if_id_stop),
    .load     (ifid_load),
    .pkt      (ifid_pkt),
    .id_inst  (id_inst),
    .id_pc    (id_pc),
    .id_pc4   (id_pc4),
    .id_valid (id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the memory returns (32'hC0DE_0000 ^ addr) on ack.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_stop;
  logic        if_id_stop;
  logic        if_id_flush;
  logic [1:0]  jump;
  logic [31:0] br_target;
  logic [31:0] jalr_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_stop     (pc_stop),
    .if_id_stop  (if_id_stop),
    .if_id_flush (if_id_flush),
    .jump        (jump),
    .br_target   (br_target),
    .jalr_target (jalr_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_inst     (id_inst),
    .id_valid    (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = imem_ack ? (32'hC0DE_0000 ^ imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_stop = 1'b0; if_id_stop = 1'b0; if_id_flush = 1'b0;
    jump = 2'd0; br_target = '0; jalr_target = '0; imem_ack = 1'b0;
    #2;
    check("rst_req",   imem_req, 1'b0);
    check("rst_inst",  id_inst,  NOP);
    check("rst_valid", id_valid, 1'b0);
    check("rst_pc",    id_pc,    32'h0);
    check("rst_pc4",   id_pc4,   32'h4);

    // Zero-wait sequential fetch
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b1;
    #1;
    check("seq_req0",  imem_req,  1'b1);
    check("seq_addr0", imem_addr, 32'h0);
    tick();
    check("seq_addr1", imem_addr, 32'h4);
    check("seq_idpc0", id_pc,     32'h0);
    check("seq_inst0", id_inst,   32'hC0DE_0000);
    check("seq_val0",  id_valid,  1'b1);
    check("seq_pc4_0", id_pc4,    32'h4);
    tick();
    check("seq_addr2", imem_addr, 32'h8);
    check("seq_idpc1", id_pc,     32'h4);
    tick();
    check("seq_idpc2", id_pc,     32'h8);
    tick();
    check("seq_addr4", imem_addr, 32'h10);
    check("seq_inst3", id_inst,   32'hC0DE_000C);

    // Load-use stall at pc 0x10 with ack
    pc_stop = 1'b1; if_id_stop = 1'b1;
    tick();
    check("stall_req",   imem_req, 1'b0);
    check("stall_idpc",  id_pc,    32'h0C);
    check("stall_inst",  id_inst,  32'hC0DE_000C);
    check("stall_valid", id_valid, 1'b1);
    pc_stop = 1'b0; if_id_stop = 1'b0;
    tick();
    check("rel_idpc",  id_pc,     32'h10);
    check("rel_inst",  id_inst,   32'hC0DE_0010);
    check("rel_req",   imem_req,  1'b1);
    check("rel_addr",  imem_addr, 32'h14);
    tick();
    check("rel_next",  id_pc,     32'h14);
    check("rel_addr2", imem_addr, 32'h18);

    // Branch redirect with ack
    jump = 2'd1; br_target = 32'h100;
    tick();
    check("br_addr",  imem_addr, 32'h100);
    check("br_valid", id_valid,  1'b0);
    check("br_inst",  id_inst,   NOP);
    check("br_pc",    id_pc,     32'h14);
    jump = 2'd0;
    tick();
    check("br_idpc",  id_pc,     32'h100);
    check("br_ival",  id_valid,  1'b1);
    check("br_next",  imem_addr, 32'h104);

    // jalr redirect during multi-cycle latency
    imem_ack = 1'b0;
    tick();
    check("lat_addr0", imem_addr, 32'h104);
    check("lat_val0",  id_valid,  1'b0);
    jump = 2'd2; jalr_target = 32'h201;
    tick();
    check("drop_addr1", imem_addr, 32'h104);
    check("drop_req1",  imem_req,  1'b1);
    jump = 2'd0;
    tick();
    check("drop_addr2", imem_addr, 32'h104);
    imem_ack = 1'b1;
    tick();
    check("drop_next",  imem_addr, 32'h200);
    check("drop_val",   id_valid,  1'b0);
    check("drop_inst",  id_inst,   NOP);
    tick();
    check("jalr_idpc",  id_pc,     32'h200);
    check("jalr_inst",  id_inst,   32'hC0DE_0200);

    // Redirect while holding a buffered instruction
    pc_stop = 1'b1; if_id_stop = 1'b1;
    tick();
    check("hold_req",  imem_req, 1'b0);
    check("hold_idpc", id_pc,    32'h200);
    pc_stop = 1'b0; if_id_stop = 1'b0; jump = 2'd1; br_target = 32'h300;
    tick();
    check("hredir_val",  id_valid,  1'b0);
    check("hredir_addr", imem_addr, 32'h300);
    check("hredir_req",  imem_req,  1'b1);
    jump = 2'd0;
    tick();
    check("hredir_idpc", id_pc,   32'h300);
    check("hredir_inst", id_inst, 32'hC0DE_0300);

    // Flush without redirect refetches the same address
    if_id_flush = 1'b1;
    tick();
    check("fl_addr", imem_addr, 32'h304);
    check("fl_val",  id_valid,  1'b0);
    check("fl_pc",   id_pc,     32'h300);
    if_id_flush = 1'b0;
    tick();
    check("fl_idpc", id_pc, 32'h304);

    // PC wrap at the top of the address space
    jump = 2'd1; br_target = 32'hFFFF_FFFC;
    tick();
    jump = 2'd0;
    tick();
    check("wrap_idpc", id_pc,     32'hFFFF_FFFC);
    check("wrap_pc4",  id_pc4,    32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_inst", id_inst,   32'h3F21_FFFC);

    // Async reset in the middle of an outstanding request
    tick();
    tick();
    imem_ack = 1'b0;
    tick();
    check("mid_addr", imem_addr, 32'h8);
    check("mid_req",  imem_req,  1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_req",   imem_req,  1'b0);
    check("arst_addr",  imem_addr, 32'h0);
    check("arst_val",   id_valid,  1'b0);
    check("arst_inst",  id_inst,   NOP);
    check("arst_pc",    id_pc,     32'h0);
    check("arst_pc4",   id_pc4,    32'h4);
    imem_ack = 1'b1;
    tick();
    check("arst_hold", id_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    check("post_req",  imem_req,  1'b1);
    check("post_addr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    tick();
    check("post_idpc", id_pc,    32'h0);
    check("post_inst", id_inst,  32'hC0DE_0000);
    check("post_val",  id_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
